// File: rtl/and_serial_arbiter_if.sv
// Requester-side bundle for and_serial_arbiter.
// Holds both request/operand channels plus the shared grant/done/result return path.
//   master : requester side (drives req/operands, observes grants and results)
//   slave  : arbiter side   (observes req/operands, drives grants and results)
interface and_serial_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, result
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, result
  );
endinterface

// File: rtl/and_serial_arbiter.sv
// Round-robin arbiter that time-shares a single external 1-bit AND cell between
// two requesters. Each granted operation is pushed LSB-first through the cell,
// one bit per clock, and the returned bits are gathered into a parallel word.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      requester bundle (slave side): req/operands in, gnt/busy/done/done_id/result out
//   and_a    to AND cell input a
//   and_b    to AND cell input b
//   and_res  from AND cell output (combinational)
//
// state  | meaning
// S_IDLE | waiting for a request; arbitrates and captures operands on grant
// S_RUN  | streaming WIDTH operand bits through the AND cell
// S_DONE | result valid for one cycle, done pulse high
module and_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  and_serial_arbiter_if.slave  bus,
  output logic                 and_a,
  output logic                 and_b,
  input  logic                 and_res
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt;
  logic             last_served;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done_id_q;
  logic             any_req;
  logic             pick1;
  logic             last_bit;

  always_comb begin
    any_req   = bus.req0 | bus.req1;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    pick1     = bus.req1 & (~bus.req0 | ~last_served);
    last_bit  = (cnt == CW'(WIDTH - 1));
    // Bits arrive LSB-first, so shifting in from the top leaves bit 0 in place after WIDTH steps.
    acc_nxt   = {and_res, acc[WIDTH-1:1]};
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    and_a     = 1'b0;
    and_b     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        and_a    = op_a[0];
        and_b    = op_b[0];
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      result_q    <= '0;
      cnt         <= '0;
      last_served <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            op_a        <= pick1 ? bus.a1 : bus.a0;
            op_b        <= pick1 ? bus.b1 : bus.b0;
            acc         <= '0;
            cnt         <= '0;
            gnt0_q      <= ~pick1;
            gnt1_q      <= pick1;
            done_id_q   <= pick1;
            last_served <= pick1;
          end
        end
        S_RUN: begin
          acc  <= acc_nxt;
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + CW'(1);
          if (last_bit) result_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_and_serial_arbiter.sv
module tb_and_serial_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic and_a;
  logic and_b;
  logic and_res;

  int checks   = 0;
  int failures = 0;

  and_serial_arbiter_if #(.WIDTH(8)) bus ();

  and_serial_arbiter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .and_a   (and_a),
    .and_b   (and_b),
    .and_res (and_res)
  );

  // The shared 1-bit AND cell.
  assign and_res = and_a & and_b;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] a_after;
    logic [7:0] exp_res;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    check("wait_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  // One operation from a single requester, starting from IDLE.
  task automatic run_op(input vec_t v, input string name);
    logic [7:0] sa;
    logic [7:0] sb;
    int         busy_cnt;
    int         done_at;
    logic [7:0] got_res;
    logic       got_id;
    sa = '0; sb = '0; busy_cnt = 0; done_at = -1; got_res = '0; got_id = 1'b0;
    @(negedge clk);
    if (v.id == 1'b0) begin
      bus.req0 = 1'b1; bus.a0 = v.a; bus.b0 = v.b;
    end else begin
      bus.req1 = 1'b1; bus.a1 = v.a; bus.b1 = v.b;
    end
    @(negedge clk);
    check({name, " gnt0"}, {31'd0, bus.gnt0}, {31'd0, ~v.id});
    check({name, " gnt1"}, {31'd0, bus.gnt1}, {31'd0, v.id});
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (v.id == 1'b0) bus.a0 = v.a_after; else bus.a1 = v.a_after;
    sa[0] = and_a;
    sb[0] = and_b;
    if (bus.busy) busy_cnt++;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i < 8) begin
        sa[i[2:0]] = and_a;
        sb[i[2:0]] = and_b;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = i;
        got_res = bus.result;
        got_id  = bus.done_id;
        break;
      end
    end
    check({name, " and_a_seq"}, {24'd0, sa}, {24'd0, v.a});
    check({name, " and_b_seq"}, {24'd0, sb}, {24'd0, v.b});
    check({name, " done_latency"}, done_at, 32'd8);
    check({name, " result"}, {24'd0, got_res}, {24'd0, v.exp_res});
    check({name, " done_id"}, {31'd0, got_id}, {31'd0, v.id});
    check({name, " busy_cycles"}, busy_cnt, 32'd9);
    @(negedge clk);
    check({name, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
    check({name, " busy_end"}, {31'd0, bus.busy}, 32'd0);
    check({name, " result_hold"}, {24'd0, bus.result}, {24'd0, v.exp_res});
  endtask

  vec_t vecs[5];

  initial begin
    int g0, g1, nd, ng, dbl, dcount;
    logic [7:0] dres[2];
    logic       did[2];
    int         gcyc[4];
    logic       gid[4];

    vecs[0] = '{1'b0, 8'hF0, 8'h3C, 8'hF0, 8'h30};
    vecs[1] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{1'b0, 8'h0F, 8'h33, 8'hFF, 8'h03};
    vecs[3] = '{1'b1, 8'hA5, 8'h5A, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 8'hFF, 8'h81, 8'h00, 8'h81};

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    reset_dut();

    // Reset state
    @(negedge clk);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check("rst result", {24'd0, bus.result}, 32'd0);
    check("rst done_id", {31'd0, bus.done_id}, 32'd0);
    check("rst and_ab", {30'd0, and_a, and_b}, 32'd0);

    for (int k = 0; k < 5; k++) run_op(vecs[k], $sformatf("vec%0d", k));

    // Tie straight after reset: requester 0 first, then 1, grants 10 cycles apart.
    reset_dut();
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 8'hAA; bus.b0 = 8'h0F;
    bus.req1 = 1'b1; bus.a1 = 8'h55; bus.b1 = 8'hF0;
    g0 = -1; g1 = -1; nd = 0; dres[0] = '0; dres[1] = '0; did[0] = 1'b0; did[1] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        if (g0 < 0) g0 = c;
        bus.req0 = 1'b0;
      end
      if (bus.gnt1) begin
        if (g1 < 0) g1 = c;
        bus.req1 = 1'b0;
      end
      if (bus.done) begin
        if (nd < 2) begin
          dres[nd] = bus.result;
          did[nd]  = bus.done_id;
        end
        nd++;
      end
    end
    check("tie gnt0_cycle", g0, 32'd1);
    check("tie gnt1_cycle", g1, 32'd11);
    check("tie done_count", nd, 32'd2);
    check("tie res0", {24'd0, dres[0]}, 32'h0A);
    check("tie id0", {31'd0, did[0]}, 32'd0);
    check("tie res1", {24'd0, dres[1]}, 32'h50);
    check("tie id1", {31'd0, did[1]}, 32'd1);

    // Both requests held: grants alternate 0,1,0,1 with fixed spacing.
    reset_dut();
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 8'h3C; bus.b0 = 8'hFF;
    bus.req1 = 1'b1; bus.a1 = 8'hC3; bus.b1 = 8'hFF;
    ng = 0; dbl = 0;
    for (int q = 0; q < 4; q++) begin gcyc[q] = -1; gid[q] = 1'b0; end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) dbl++;
      if (bus.gnt0 || bus.gnt1) begin
        if (ng < 4) begin
          gcyc[ng] = c;
          gid[ng]  = bus.gnt1;
        end
        ng++;
        if (ng == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
    end
    check("fair grant_count", ng, 32'd4);
    check("fair double_gnt", dbl, 32'd0);
    check("fair order", {28'd0, gid[3], gid[2], gid[1], gid[0]}, 32'b1010);
    for (int q = 1; q < 4; q++)
      check($sformatf("fair spacing%0d", q), gcyc[q] - gcyc[q-1], 32'd10);
    wait_idle();

    // Reset at RUN bit 3: abort, no done, priority back to requester 0.
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'hFF;
    @(negedge clk);
    check("abort gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort in_run", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort result", {24'd0, bus.result}, 32'd0);
    check("abort and_ab", {30'd0, and_a, and_b}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("abort no_done", dcount, 32'd0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    check("abort tie_gnt0", {31'd0, bus.gnt0}, 32'd1);
    check("abort tie_gnt1", {31'd0, bus.gnt1}, 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    wait_idle();
    run_op('{1'b1, 8'hC3, 8'h96, 8'h00, 8'h82}, "post_abort");

    // Reset and request together: reset wins.
    @(negedge clk);
    rst = 1'b1; bus.req0 = 1'b1;
    @(negedge clk);
    check("rst_req gnt0", {31'd0, bus.gnt0}, 32'd0);
    check("rst_req busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0; bus.req0 = 1'b0;
    @(negedge clk);
    check("rst_req idle", {30'd0, bus.busy, bus.gnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
